sentinel_monitor_mc: RTL and testbench

Multi-channel, parametrised successor to the single-channel sentinel monitor. It watches NUM_CH independent 2-bit status codes: 00=OK, 01=VETO, 10=THERMAL, 11=AI FAULT. Each channel has a glitch-rejection FSM, a saturating audit counter, a first-cause latch and per-channel clear. A registered read port and a global saturating total feed the edge telemetry/audit path.

---
 rtl/sentinel_monitor_mc.sv | 191 +++++++++++++++++++
 tb/tb_sentinel_monitor_mc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sentinel_monitor_mc.sv
// Multi-channel sentinel monitor: per-channel glitch filter FSM,
// saturating audit counters, first-cause latch and clear.
// Ports: clk, rst_n (sync, active-low), status_in (2 bits/channel),
// clr_valid/clr_ch/clr_all clears, rd_valid_in/rd_ch read request;
// ch_active/ch_latched/alert_any/latched_any status, total_count,
// rd_valid_out/rd_count/rd_cause/rd_latched registered read data.
module sentinel_monitor_mc #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int TOT_W   = 16,
  parameter int PERSIST = 1,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*NUM_CH-1:0] status_in,
  input  logic                clr_valid,
  input  logic [CH_W-1:0]     clr_ch,
  input  logic                clr_all,
  input  logic                rd_valid_in,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [NUM_CH-1:0]   ch_active,
  output logic [NUM_CH-1:0]   ch_latched,
  output logic                alert_any,
  output logic                latched_any,
  output logic [TOT_W-1:0]    total_count,
  output logic                rd_valid_out,
  output logic [CNT_W-1:0]    rd_count,
  output logic [1:0]          rd_cause,
  output logic                rd_latched
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } st_e;

  st_e              st_q    [NUM_CH];
  st_e              st_d    [NUM_CH];
  logic [7:0]       pc_q    [NUM_CH];
  logic [7:0]       pc_d    [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [1:0]       cause_q [NUM_CH];
  logic [1:0]       cause_d [NUM_CH];
  logic [NUM_CH-1:0] lat_q;
  logic [NUM_CH-1:0] lat_d;
  logic [NUM_CH-1:0] conf;
  logic [TOT_W-1:0]  tot_q;
  logic [TOT_W-1:0]  tot_d;
  logic [TOT_W:0]    add;
  logic [TOT_W:0]    sum;

  logic             rv_q;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]       rcause_q, rcause_d;
  logic             rlat_q, rlat_d;

  // FSM next state; conf marks the edge a violation is confirmed
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c] = st_q[c];
      pc_d[c] = pc_q[c];
      conf[c] = 1'b0;
      unique case (st_q[c])
        IDLE: begin
          if (status_in[2*c +: 2] != 2'b00) begin
            if (PERSIST == 1) begin
              st_d[c] = ACTIVE;
              conf[c] = 1'b1;
            end else begin
              st_d[c] = PEND;
              pc_d[c] = 8'd1;
            end
          end
        end
        PEND: begin
          if (status_in[2*c +: 2] == 2'b00) begin
            st_d[c] = IDLE;
            pc_d[c] = 8'd0;
          end else if (pc_q[c] + 8'd1 == 8'(PERSIST)) begin
            st_d[c] = ACTIVE;
            pc_d[c] = 8'd0;
            conf[c] = 1'b1;
          end else begin
            pc_d[c] = pc_q[c] + 8'd1;
          end
        end
        ACTIVE: begin
          if (status_in[2*c +: 2] == 2'b00)
            st_d[c] = IDLE;
        end
        default: begin
          st_d[c] = IDLE;
          pc_d[c] = 8'd0;
        end
      endcase
    end
  end

  // Audit state: clear first, then a same-edge confirm lands on top
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]   = cnt_q[c];
      cause_d[c] = cause_q[c];
      lat_d[c]   = lat_q[c];
      if (clr_all || (clr_valid && clr_ch == CH_W'(c))) begin
        cnt_d[c]   = '0;
        cause_d[c] = 2'b00;
        lat_d[c]   = 1'b0;
      end
      if (conf[c]) begin
        if (cnt_d[c] != '1)
          cnt_d[c] = cnt_d[c] + CNT_W'(1);
        if (!lat_d[c])
          cause_d[c] = status_in[2*c +: 2];
        lat_d[c] = 1'b1;
      end
    end
  end

  // Total: sum has one guard bit, so a set MSB means overflow
  always_comb begin
    add = '0;
    for (int c = 0; c < NUM_CH; c++)
      add = add + {{TOT_W{1'b0}}, conf[c]};
    sum = {1'b0, (clr_all ? '0 : tot_q)} + add;
    tot_d = sum[TOT_W] ? '1 : sum[TOT_W-1:0];
  end

  // Read mux over pre-update state; unmatched channel gives zeros
  always_comb begin
    rcnt_d   = '0;
    rcause_d = 2'b00;
    rlat_d   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        rcnt_d   = cnt_q[c];
        rcause_d = cause_q[c];
        rlat_d   = lat_q[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]    <= IDLE;
        pc_q[c]    <= 8'd0;
        cnt_q[c]   <= '0;
        cause_q[c] <= 2'b00;
      end
      lat_q    <= '0;
      tot_q    <= '0;
      rv_q     <= 1'b0;
      rcnt_q   <= '0;
      rcause_q <= 2'b00;
      rlat_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]    <= st_d[c];
        pc_q[c]    <= pc_d[c];
        cnt_q[c]   <= cnt_d[c];
        cause_q[c] <= cause_d[c];
      end
      lat_q <= lat_d;
      tot_q <= tot_d;
      rv_q  <= rd_valid_in;
      if (rd_valid_in) begin
        rcnt_q   <= rcnt_d;
        rcause_q <= rcause_d;
        rlat_q   <= rlat_d;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      ch_active[c] = (st_q[c] == ACTIVE);
    ch_latched   = lat_q;
    alert_any    = |ch_active;
    latched_any  = |lat_q;
    total_count  = tot_q;
    rd_valid_out = rv_q;
    rd_count     = rcnt_q;
    rd_cause     = rcause_q;
    rd_latched   = rlat_q;
  end

endmodule

// File: tb/tb_sentinel_monitor_mc.sv
// Directed bench for sentinel_monitor_mc: instance A has 4 channels
// with PERSIST=1, instance B has 5 channels with PERSIST=3.
module tb_sentinel_monitor_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [7:0]  a_st;
  logic        a_cv, a_ca, a_rv;
  logic [1:0]  a_cc, a_rc;
  logic [3:0]  a_act, a_lat;
  logic        a_aany, a_lany, a_rvo, a_rlat;
  logic [15:0] a_tot;
  logic [7:0]  a_rcnt;
  logic [1:0]  a_rcause;

  logic [9:0]  b_st;
  logic        b_cv, b_ca, b_rv;
  logic [2:0]  b_cc, b_rc;
  logic [4:0]  b_act, b_lat;
  logic        b_aany, b_lany, b_rvo, b_rlat;
  logic [15:0] b_tot;
  logic [7:0]  b_rcnt;
  logic [1:0]  b_rcause;

  int n_chk = 0;
  int n_fail = 0;

  sentinel_monitor_mc #(.NUM_CH(4), .PERSIST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .status_in(a_st),
    .clr_valid(a_cv), .clr_ch(a_cc), .clr_all(a_ca),
    .rd_valid_in(a_rv), .rd_ch(a_rc),
    .ch_active(a_act), .ch_latched(a_lat),
    .alert_any(a_aany), .latched_any(a_lany),
    .total_count(a_tot), .rd_valid_out(a_rvo),
    .rd_count(a_rcnt), .rd_cause(a_rcause),
    .rd_latched(a_rlat));

  sentinel_monitor_mc #(.NUM_CH(5), .PERSIST(3)) u_b (
    .clk(clk), .rst_n(rst_n), .status_in(b_st),
    .clr_valid(b_cv), .clr_ch(b_cc), .clr_all(b_ca),
    .rd_valid_in(b_rv), .rd_ch(b_rc),
    .ch_active(b_act), .ch_latched(b_lat),
    .alert_any(b_aany), .latched_any(b_lany),
    .total_count(b_tot), .rd_valid_out(b_rvo),
    .rd_count(b_rcnt), .rd_cause(b_rcause),
    .rd_latched(b_rlat));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_chk++; if (a_act !== 4'b0) begin n_fail++; $display("FAIL rst_act got %b exp 0", a_act); end
    n_chk++; if (a_lat !== 4'b0) begin n_fail++; $display("FAIL rst_lat got %b exp 0", a_lat); end
    n_chk++; if ({a_aany, a_lany, a_rvo, a_rlat} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b exp 0", {a_aany, a_lany, a_rvo, a_rlat}); end
    n_chk++; if (a_tot !== 16'd0 || a_rcnt !== 8'd0 || a_rcause !== 2'd0) begin n_fail++; $display("FAIL rst_data got %0d/%0d/%0d exp 0", a_tot, a_rcnt, a_rcause); end
    n_chk++; if (b_act !== 5'b0 || b_tot !== 16'd0 || b_rvo !== 1'b0) begin n_fail++; $display("FAIL rst_b got %b/%0d/%b exp 0", b_act, b_tot, b_rvo); end
  endtask

  task automatic test_persist1();
    logic [1:0] seq [5];
    logic       exp [5];
    seq = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
    exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      a_st = {6'b0, seq[i]};
      tick();
      n_chk++; if (a_aany !== exp[i]) begin n_fail++; $display("FAIL p1_alert[%0d] got %b exp %b", i, a_aany, exp[i]); end
    end
    a_st = 8'h00; a_rv = 1'b1; a_rc = 2'd0;
    tick();
    a_rv = 1'b0;
    n_chk++; if (a_rvo !== 1'b1) begin n_fail++; $display("FAIL p1_rvo got %b exp 1", a_rvo); end
    n_chk++; if (a_rcnt !== 8'd2) begin n_fail++; $display("FAIL p1_count got %0d exp 2", a_rcnt); end
    n_chk++; if (a_rcause !== 2'b01) begin n_fail++; $display("FAIL p1_cause got %b exp 01", a_rcause); end
    n_chk++; if (a_rlat !== 1'b1 || a_lat !== 4'b0001 || a_lany !== 1'b1) begin n_fail++; $display("FAIL p1_latched got %b/%b/%b exp 1/0001/1", a_rlat, a_lat, a_lany); end
    n_chk++; if (a_tot !== 16'd2) begin n_fail++; $display("FAIL p1_total got %0d exp 2", a_tot); end
  endtask

  task automatic test_persist3();
    logic [1:0] seq [7];
    logic       exp [7];
    seq = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10};
    exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      b_st = {6'b0, seq[i], 2'b00};
      tick();
      n_chk++; if (b_act[1] !== exp[i]) begin n_fail++; $display("FAIL p3_active[%0d] got %b exp %b", i, b_act[1], exp[i]); end
      n_chk++; if (b_tot !== {15'd0, exp[i]}) begin n_fail++; $display("FAIL p3_total[%0d] got %0d exp %0d", i, b_tot, exp[i]); end
    end
    b_st = 10'h0; b_rv = 1'b1; b_rc = 3'd1;
    tick();
    b_rv = 1'b0;
    n_chk++; if (b_rcnt !== 8'd1 || b_rcause !== 2'b10 || b_rlat !== 1'b1) begin n_fail++; $display("FAIL p3_read got %0d/%b/%b exp 1/10/1", b_rcnt, b_rcause, b_rlat); end
    tick();
    n_chk++; if (b_rvo !== 1'b0 || b_rcnt !== 8'd1) begin n_fail++; $display("FAIL rd_hold got %b/%0d exp 0/1", b_rvo, b_rcnt); end
  endtask

  task automatic test_out_of_range();
    b_cv = 1'b1; b_cc = 3'd5;
    tick();
    b_cv = 1'b0;
    n_chk++; if (b_lat !== 5'b00010) begin n_fail++; $display("FAIL oor_clr_lat got %b exp 00010", b_lat); end
    b_rv = 1'b1; b_rc = 3'd1;
    tick();
    n_chk++; if (b_rcnt !== 8'd1) begin n_fail++; $display("FAIL oor_clr_cnt got %0d exp 1", b_rcnt); end
    b_rc = 3'd6;
    tick();
    b_rv = 1'b0;
    n_chk++; if (b_rvo !== 1'b1 || b_rcnt !== 8'd0 || b_rcause !== 2'd0 || b_rlat !== 1'b0) begin n_fail++; $display("FAIL oor_read got %b/%0d/%b/%b exp 1/0/00/0", b_rvo, b_rcnt, b_rcause, b_rlat); end
  endtask

  task automatic test_saturate();
    a_ca = 1'b1;
    tick();
    a_ca = 1'b0;
    n_chk++; if (a_tot !== 16'd0 || a_lat !== 4'b0) begin n_fail++; $display("FAIL clr_all got %0d/%b exp 0/0000", a_tot, a_lat); end
    for (int i = 0; i < 300; i++) begin
      a_st = 8'h00;
      tick();
      a_st = 8'b0010_0000;
      tick();
    end
    a_st = 8'h00; a_rv = 1'b1; a_rc = 2'd2;
    tick();
    a_rv = 1'b0;
    n_chk++; if (a_rcnt !== 8'd255) begin n_fail++; $display("FAIL sat_count got %0d exp 255", a_rcnt); end
    n_chk++; if (a_rcause !== 2'b10 || a_rlat !== 1'b1) begin n_fail++; $display("FAIL sat_cause got %b/%b exp 10/1", a_rcause, a_rlat); end
    n_chk++; if (a_tot !== 16'd300) begin n_fail++; $display("FAIL sat_total got %0d exp 300", a_tot); end
  endtask

  task automatic test_back_to_back();
    a_ca = 1'b1;
    tick();
    a_ca = 1'b0;
    a_st = 8'b1100_0001;
    tick();
    n_chk++; if (a_tot !== 16'd2) begin n_fail++; $display("FAIL dual_total got %0d exp 2", a_tot); end
    n_chk++; if (a_act !== 4'b1001) begin n_fail++; $display("FAIL dual_active got %b exp 1001", a_act); end
    a_st = 8'h00;
    tick();
    n_chk++; if (a_act !== 4'b0000 || a_aany !== 1'b0) begin n_fail++; $display("FAIL dual_idle got %b/%b exp 0000/0", a_act, a_aany); end
  endtask

  task automatic test_clear_confirm();
    a_st = 8'b0000_0011; a_cv = 1'b1; a_cc = 2'd0;
    tick();
    a_cv = 1'b0;
    n_chk++; if (a_tot !== 16'd3) begin n_fail++; $display("FAIL cc_total got %0d exp 3", a_tot); end
    a_st = 8'h00; a_rv = 1'b1; a_rc = 2'd0;
    tick();
    a_rv = 1'b0;
    n_chk++; if (a_rcnt !== 8'd1 || a_rcause !== 2'b11 || a_rlat !== 1'b1) begin n_fail++; $display("FAIL cc_read got %0d/%b/%b exp 1/11/1", a_rcnt, a_rcause, a_rlat); end
    n_chk++; if (a_lat !== 4'b1001) begin n_fail++; $display("FAIL cc_lat got %b exp 1001", a_lat); end
  endtask

  task automatic test_read_snapshot();
    a_st = 8'b0000_0001; a_rv = 1'b1; a_rc = 2'd0;
    tick();
    n_chk++; if (a_rvo !== 1'b1 || a_rcnt !== 8'd1) begin n_fail++; $display("FAIL snap_old got %b/%0d exp 1/1", a_rvo, a_rcnt); end
    tick();
    a_rv = 1'b0;
    n_chk++; if (a_rcnt !== 8'd2 || a_rcause !== 2'b11) begin n_fail++; $display("FAIL snap_new got %0d/%b exp 2/11", a_rcnt, a_rcause); end
  endtask

  task automatic test_reset_mid();
    a_st = 8'b0000_1001;
    tick();
    n_chk++; if (a_act !== 4'b0011) begin n_fail++; $display("FAIL mid_pre got %b exp 0011", a_act); end
    rst_n = 1'b0; a_rv = 1'b1; a_rc = 2'd0;
    tick();
    rst_n = 1'b1; a_rv = 1'b0; a_st = 8'h00;
    n_chk++; if (a_act !== 4'b0 || a_lat !== 4'b0 || a_aany !== 1'b0 || a_lany !== 1'b0) begin n_fail++; $display("FAIL mid_state got %b/%b/%b/%b exp 0", a_act, a_lat, a_aany, a_lany); end
    n_chk++; if (a_tot !== 16'd0) begin n_fail++; $display("FAIL mid_total got %0d exp 0", a_tot); end
    n_chk++; if (a_rvo !== 1'b0 || a_rcnt !== 8'd0 || a_rcause !== 2'd0 || a_rlat !== 1'b0) begin n_fail++; $display("FAIL mid_read got %b/%0d/%b/%b exp 0", a_rvo, a_rcnt, a_rcause, a_rlat); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_st = '0; a_cv = 0; a_cc = '0; a_ca = 0; a_rv = 0; a_rc = '0;
    b_st = '0; b_cv = 0; b_cc = '0; b_ca = 0; b_rv = 0; b_rc = '0;
    test_reset();
    test_persist1();
    test_persist3();
    test_out_of_range();
    test_saturate();
    test_back_to_back();
    test_clear_confirm();
    test_read_snapshot();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
